// File: rtl/demux4to1_32bit_buf.sv
// Registered 1-to-4 demultiplexer with a single-entry buffer per output channel.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_data, ctr     word to route and its destination channel (00..11 -> ch0..ch3)
//   in_valid         producer has a word; in_ready: block can take it this cycle
//   out_00..out_11   buffered word per channel, valid when out_valid[i]
//   out_ready        per-channel consumer take strobe
//   cnt_00..cnt_11   per-channel delivered-word counters (wrap modulo 2^CNT_W)
//   busy             any channel buffer holds a word
module demux4to1_32bit_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       ctr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_00,
  output logic [WIDTH-1:0] out_01,
  output logic [WIDTH-1:0] out_10,
  output logic [WIDTH-1:0] out_11,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt_00,
  output logic [CNT_W-1:0] cnt_01,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_11,
  output logic             busy
);

  localparam int unsigned NCH = 4;

  logic [NCH-1:0]   full;
  logic [WIDTH-1:0] buf_q [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];

  logic [NCH-1:0] sel;
  logic [NCH-1:0] acc;
  logic [NCH-1:0] drain;
  logic           accept;

  // Handshake decode; in_ready looks through to out_ready so a draining
  // channel can be refilled in the same cycle.
  always_comb begin
    sel      = NCH'(1) << ctr;
    in_ready = !rst && (!full[ctr] || out_ready[ctr]);
    accept   = in_valid && in_ready;
    acc      = accept ? sel : '0;
    drain    = full & out_ready;
  end

  // Per-channel buffer, occupancy and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
      for (int i = 0; i < NCH; i++) begin
        buf_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // A refill wins over a drain: the slot stays occupied with the new word.
        if (acc[i]) begin
          buf_q[i] <= in_data;
          full[i]  <= 1'b1;
        end else if (drain[i]) begin
          full[i]  <= 1'b0;
        end
        if (drain[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = full;
  assign busy      = |full;
  assign out_00    = buf_q[0];
  assign out_01    = buf_q[1];
  assign out_10    = buf_q[2];
  assign out_11    = buf_q[3];
  assign cnt_00    = cnt_q[0];
  assign cnt_01    = cnt_q[1];
  assign cnt_10    = cnt_q[2];
  assign cnt_11    = cnt_q[3];

endmodule

// File: tb/tb_demux4to1_32bit_buf.sv
// Self-checking bench for demux4to1_32bit_buf: table-driven directed vectors,
// hand-written multi-cycle sequences and random traffic, all checked against
// a per-channel slot model. A second instance with CNT_W=4 covers counter wrap.
module tb_demux4to1_32bit_buf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 16)
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  ctr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_00, out_01, out_10, out_11;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] cnt_00, cnt_01, cnt_10, cnt_11;
  logic        busy;

  demux4to1_32bit_buf #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .ctr(ctr), .in_valid(in_valid),
    .in_ready(in_ready), .out_00(out_00), .out_01(out_01), .out_10(out_10),
    .out_11(out_11), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_00(cnt_00), .cnt_01(cnt_01), .cnt_10(cnt_10), .cnt_11(cnt_11),
    .busy(busy)
  );

  // Narrow-counter instance for the wrap check
  logic        w_rst;
  logic [31:0] w_data;
  logic [1:0]  w_ctr;
  logic        w_valid;
  logic        w_in_ready;
  logic [31:0] w_o0, w_o1, w_o2, w_o3;
  logic [3:0]  w_ovalid;
  logic [3:0]  w_oready;
  logic [3:0]  w_c0, w_c1, w_c2, w_c3;
  logic        w_busy;

  demux4to1_32bit_buf #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(w_rst), .in_data(w_data), .ctr(w_ctr), .in_valid(w_valid),
    .in_ready(w_in_ready), .out_00(w_o0), .out_01(w_o1), .out_10(w_o2),
    .out_11(w_o3), .out_valid(w_ovalid), .out_ready(w_oready),
    .cnt_00(w_c0), .cnt_01(w_c1), .cnt_10(w_c2), .cnt_11(w_c3),
    .busy(w_busy)
  );

  logic [31:0] outs [4];
  logic [15:0] cnts [4];
  assign outs[0] = out_00;
  assign outs[1] = out_01;
  assign outs[2] = out_10;
  assign outs[3] = out_11;
  assign cnts[0] = cnt_00;
  assign cnts[1] = cnt_01;
  assign cnts[2] = cnt_10;
  assign cnts[3] = cnt_11;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel is a one-word slot plus a delivered count.
  bit          m_full [4];
  logic [31:0] m_word [4];
  logic [15:0] m_cnt  [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = '0;
      m_cnt[i]  = '0;
    end
  endtask

  // One clock cycle: drive, check everything visible against the model, then
  // advance the model by the effect of the coming rising edge.
  task automatic do_cycle(input bit r, input bit v, input logic [1:0] c,
                          input logic [31:0] d, input logic [3:0] o,
                          output bit rdy_exp);
    logic [3:0] vexp;
    @(negedge clk);
    rst = r; in_valid = v; ctr = c; in_data = d; out_ready = o;
    #1;
    rdy_exp = !r && (!m_full[c] || o[c]);
    chk("in_ready", 64'(in_ready), 64'(rdy_exp));
    for (int i = 0; i < 4; i++) vexp[i] = m_full[i];
    chk("out_valid", 64'(out_valid), 64'(vexp));
    chk("busy", 64'(busy), 64'(vexp != 4'b0000));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_ch%0d", i), 64'(outs[i]), 64'(m_word[i]));
      chk($sformatf("cnt_ch%0d", i), 64'(cnts[i]), 64'(m_cnt[i]));
    end
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_full[i] && o[i]) begin
          m_full[i] = 1'b0;
          m_cnt[i]  = m_cnt[i] + 16'd1;
        end
      end
      if (v && rdy_exp) begin
        m_full[c] = 1'b1;
        m_word[c] = d;
      end
    end
  endtask

  typedef struct {
    bit          r;
    bit          v;
    logic [1:0]  c;
    logic [31:0] d;
    logic [3:0]  o;
    bit          exp_ready;
    logic [3:0]  exp_valid;
  } vec_t;

  vec_t vecs [12];

  initial begin
    bit          rdy;
    logic [15:0] cnt_before;

    // Directed table: reset with in_valid held, fan-out, backpressure, drain.
    vecs[0]  = '{1, 1, 2'd0, 32'hDEAD0000, 4'b0000, 0, 4'b0000};
    vecs[1]  = '{1, 1, 2'd1, 32'hBEEF0000, 4'b0000, 0, 4'b0000};
    vecs[2]  = '{0, 1, 2'd0, 32'hAAAA0000, 4'b0000, 1, 4'b0000};
    vecs[3]  = '{0, 1, 2'd1, 32'hBBBB0001, 4'b0000, 1, 4'b0001};
    vecs[4]  = '{0, 1, 2'd2, 32'hCCCC0002, 4'b0000, 1, 4'b0011};
    vecs[5]  = '{0, 1, 2'd3, 32'hDDDD0003, 4'b0000, 1, 4'b0111};
    vecs[6]  = '{0, 0, 2'd0, 32'h00000000, 4'b0000, 0, 4'b1111};
    vecs[7]  = '{0, 1, 2'd2, 32'h12345678, 4'b0000, 0, 4'b1111};
    vecs[8]  = '{0, 1, 2'd2, 32'h12345678, 4'b0100, 1, 4'b1111};
    vecs[9]  = '{0, 0, 2'd0, 32'h00000000, 4'b0000, 0, 4'b1111};
    vecs[10] = '{0, 0, 2'd0, 32'h00000000, 4'b1111, 1, 4'b1111};
    vecs[11] = '{0, 0, 2'd0, 32'h00000000, 4'b0000, 1, 4'b0000};

    // Bring both instances out of an unknown power-up state.
    rst = 1'b1; in_valid = 1'b0; ctr = '0; in_data = '0; out_ready = '0;
    w_rst = 1'b1; w_valid = 1'b0; w_ctr = '0; w_data = '0; w_oready = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    w_rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      do_cycle(vecs[k].r, vecs[k].v, vecs[k].c, vecs[k].d, vecs[k].o, rdy);
      chk($sformatf("vec%0d_ready", k), 64'(in_ready), 64'(vecs[k].exp_ready));
      chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vecs[k].exp_valid));
      if (k == 6) begin
        chk("fanout_out00", 64'(out_00), 64'h0000_0000_AAAA_0000);
        chk("fanout_out01", 64'(out_01), 64'h0000_0000_BBBB_0001);
        chk("fanout_out10", 64'(out_10), 64'h0000_0000_CCCC_0002);
        chk("fanout_out11", 64'(out_11), 64'h0000_0000_DDDD_0003);
      end
      if (k == 7) chk("stall_out10_held", 64'(out_10), 64'h0000_0000_CCCC_0002);
      if (k == 9) begin
        chk("refill_out10", 64'(out_10), 64'h0000_0000_1234_5678);
        chk("refill_cnt10", 64'(cnt_10), 64'd1);
      end
    end

    // Streaming 100 words into ch1 with its consumer always ready.
    cnt_before = cnt_01;
    for (int k = 0; k < 100; k++) begin
      do_cycle(0, 1, 2'd1, 32'(k), 4'b0010, rdy);
      chk("stream_accept", 64'(in_ready), 64'd1);
      if (k > 0) chk("stream_order", 64'(out_01), 64'(k - 1));
    end
    do_cycle(0, 0, 2'd1, 32'h0, 4'b0010, rdy);
    chk("stream_last", 64'(out_01), 64'd99);
    do_cycle(0, 0, 2'd1, 32'h0, 4'b0000, rdy);
    chk("stream_cnt", 64'(cnt_01 - cnt_before), 64'd100);

    // Reset mid-operation: fill three channels, reset while consumers are ready.
    do_cycle(0, 1, 2'd0, 32'h0A0A0A0A, 4'b0000, rdy);
    do_cycle(0, 1, 2'd1, 32'h0B0B0B0B, 4'b0000, rdy);
    do_cycle(0, 1, 2'd2, 32'h0C0C0C0C, 4'b0000, rdy);
    do_cycle(1, 1, 2'd3, 32'h0D0D0D0D, 4'b1111, rdy);
    do_cycle(0, 1, 2'd3, 32'h5A5A5A5A, 4'b0000, rdy);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_cnt", 64'({cnt_00, cnt_01, cnt_10, cnt_11}), 64'd0);
    do_cycle(0, 0, 2'd0, 32'h0, 4'b0000, rdy);
    chk("post_rst_valid", 64'(out_valid), 64'b1000);
    chk("post_rst_word", 64'(out_11), 64'h0000_0000_5A5A_5A5A);

    // Random traffic against the model, with occasional resets.
    for (int k = 0; k < 600; k++) begin
      do_cycle(($urandom_range(0, 59) == 0), 1'($urandom), 2'($urandom),
               $urandom, 4'($urandom), rdy);
    end

    // Counter wrap on the 4-bit instance: 17 words through ch3.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      w_valid = 1'b1; w_ctr = 2'd3; w_data = 32'(k + 100); w_oready = 4'b1000;
      #1;
      chk("wrap_accept", 64'(w_in_ready), 64'd1);
      if (k == 16) chk("wrap_cnt_at16", 64'(w_c3), 64'd15);
    end
    @(negedge clk);
    w_valid = 1'b0; w_oready = 4'b1000;
    #1;
    chk("wrap_cnt_pre", 64'(w_c3), 64'd0);
    @(negedge clk);
    w_oready = 4'b0000;
    #1;
    chk("wrap_cnt", 64'(w_c3), 64'd1);
    chk("wrap_other_cnt", 64'({w_c0, w_c1, w_c2}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
